// File: rtl/sysbus_arbiter.sv
// Two-master Sysbus arbiter: round-robin grant, one outstanding transaction,
// burst routing of read responses and write data beats to the granted master.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif

module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_reqack,
  output logic                      m0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m0_respack,
  input  logic                      m1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_reqack,
  output logic                      m1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  input  logic                      m1_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      grant,
  output logic                      busy
);

  localparam int CW = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t                    state, state_nx;
  logic                      last_grant;
  logic                      grant_q;
  logic                      ack_q;
  logic [CW-1:0]             beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] req_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;

  logic                      any_req;
  logic                      win;
  logic                      is_read;
  logic                      last_beat;
  logic                      g_reqcyc;
  logic                      g_respack;
  logic [BUS_DATA_WIDTH-1:0] g_req;
  logic                      wbeat;
  logic                      rbeat;
  logic                      wack;
  logic                      rsel;

  assign any_req   = m0_reqcyc | m1_reqcyc;
  // On a tie the master that did not win last time goes first.
  assign win       = (m0_reqcyc & m1_reqcyc) ? ~last_grant : m1_reqcyc;
  assign is_read   = tag_q[BUS_TAG_WIDTH-1] == `SYSBUS_READ;
  assign last_beat = beat_cnt == CW'(BEATS - 1);
  assign g_reqcyc  = grant_q ? m1_reqcyc : m0_reqcyc;
  assign g_req     = grant_q ? m1_req : m0_req;
  assign g_respack = grant_q ? m1_respack : m0_respack;
  assign wbeat     = (state == WDATA) & g_reqcyc & bus_reqack;
  assign rbeat     = (state == RESP) & bus_respcyc & g_respack;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    wack        = 1'b0;
    rsel        = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = REQ;
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = req_q;
        bus_reqtag = tag_q;
        if (bus_reqack) state_nx = is_read ? RESP : WDATA;
      end
      WDATA: begin
        bus_reqcyc = g_reqcyc;
        bus_req    = g_req;
        bus_reqtag = tag_q;
        wack       = bus_reqack;
        if (wbeat && last_beat) state_nx = IDLE;
      end
      RESP: begin
        rsel        = 1'b1;
        bus_respack = g_respack;
        if (rbeat && last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      ack_q      <= 1'b0;
      beat_cnt   <= '0;
      req_q      <= '0;
      tag_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      if (state == IDLE && any_req) begin
        grant_q <= win;
        req_q   <= win ? m1_req : m0_req;
        tag_q   <= win ? m1_reqtag : m0_reqtag;
      end
      if (state == REQ && bus_reqack) begin
        ack_q    <= 1'b1;
        beat_cnt <= '0;
      end
      if (wbeat || rbeat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (last_beat) last_grant <= grant_q;
      end
    end
  end

  assign m0_reqack  = ~grant_q & (ack_q | wack);
  assign m1_reqack  = grant_q & (ack_q | wack);
  assign m0_respcyc = rsel & ~grant_q & bus_respcyc;
  assign m1_respcyc = rsel & grant_q & bus_respcyc;
  assign m0_resp    = (rsel & ~grant_q) ? bus_resp : '0;
  assign m1_resp    = (rsel & grant_q) ? bus_resp : '0;
  assign m0_resptag = (rsel & ~grant_q) ? bus_resptag : '0;
  assign m1_resptag = (rsel & grant_q) ? bus_resptag : '0;
  assign grant      = grant_q;
  assign busy       = state != IDLE;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reset, reads, writes, round-robin,
// response stalls and mid-burst reset.
module tb_sysbus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam logic [TW-1:0] RD = 13'h1005;
  localparam logic [TW-1:0] WR = 13'h0005;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_reqcyc = 0, m1_reqcyc = 0;
  logic [DW-1:0] m0_req = '0, m1_req = '0;
  logic [TW-1:0] m0_reqtag = '0, m1_reqtag = '0;
  logic          m0_reqack, m1_reqack;
  logic          m0_respcyc, m1_respcyc;
  logic [DW-1:0] m0_resp, m1_resp;
  logic [TW-1:0] m0_resptag, m1_resptag;
  logic          m0_respack = 0, m1_respack = 0;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack = 0;
  logic          bus_respcyc = 0;
  logic [DW-1:0] bus_resp = '0;
  logic [TW-1:0] bus_resptag = '0;
  logic          bus_respack;
  logic          grant, busy;

  int n_cmp = 0;
  int n_err = 0;

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag),
    .m0_reqack(m0_reqack), .m0_respcyc(m0_respcyc), .m0_resp(m0_resp),
    .m0_resptag(m0_resptag), .m0_respack(m0_respack),
    .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag),
    .m1_reqack(m1_reqack), .m1_respcyc(m1_respcyc), .m1_resp(m1_resp),
    .m1_resptag(m1_resptag), .m1_respack(m1_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_reqcyc = 1; m0_req = 64'h1000; m0_reqtag = RD;
    repeat (3) tick();
    n_cmp++;
    if ({bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc,
         m1_respcyc, grant, busy} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs got %b req 0", {bus_reqcyc, bus_respack,
               m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, grant, busy});
    end
    n_cmp++;
    if (bus_req !== '0 || bus_reqtag !== '0) begin
      n_err++;
      $display("FAIL reset_bus_req got %h/%h req 0", bus_req, bus_reqtag);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus_reqcyc !== 1 || bus_req !== 64'h1000 || bus_reqtag !== RD) begin
      n_err++;
      $display("FAIL reset_release_req got %b %h %h req 1 1000 %h",
               bus_reqcyc, bus_req, bus_reqtag, RD);
    end
    m0_reqcyc = 0;
    pulse_reset();
  endtask

  task automatic test_read();
    int acks = 0;
    int beats = 0;
    m0_reqcyc = 1; m0_req = 64'h2000; m0_reqtag = RD;
    tick();
    m0_req = 64'hdead;
    #1;
    n_cmp++;
    if (bus_reqcyc !== 1 || bus_req !== 64'h2000 || grant !== 0) begin
      n_err++;
      $display("FAIL read_req got %b %h g%b req 1 2000 g0",
               bus_reqcyc, bus_req, grant);
    end
    tick();
    n_cmp++;
    if (bus_reqcyc !== 1 || bus_req !== 64'h2000) begin
      n_err++;
      $display("FAIL read_req_hold got %b %h req 1 2000", bus_reqcyc, bus_req);
    end
    acks += int'(m0_reqack);
    bus_reqack = 1;
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    acks += int'(m0_reqack);
    n_cmp++;
    if (bus_reqcyc !== 0 || busy !== 1) begin
      n_err++;
      $display("FAIL read_after_ack got reqcyc %b busy %b req 0 1",
               bus_reqcyc, busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1; bus_resp = 64'h11 * (i + 1); bus_resptag = RD;
      m0_respack = 1;
      #1;
      if (i > 0) acks += int'(m0_reqack);
      if (m0_respcyc === 1 && m0_resp === 64'h11 * (i + 1)) beats++;
      n_cmp++;
      if (m1_respcyc !== 0 || bus_respack !== 1) begin
        n_err++;
        $display("FAIL read_route beat %0d got m1 %b ack %b req 0 1",
                 i, m1_respcyc, bus_respack);
      end
      tick();
    end
    bus_respcyc = 0; m0_respack = 0;
    n_cmp++;
    if (beats !== 8) begin
      n_err++;
      $display("FAIL read_beats got %0d req 8", beats);
    end
    n_cmp++;
    if (acks !== 1) begin
      n_err++;
      $display("FAIL read_reqack_pulses got %0d req 1", acks);
    end
    n_cmp++;
    if (busy !== 0) begin
      n_err++;
      $display("FAIL read_busy_end got %b req 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    m0_reqcyc = 1; m0_req = 64'hA000; m0_reqtag = RD;
    m1_reqcyc = 1; m1_req = 64'hB000; m1_reqtag = RD;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      tick();
      n_cmp++;
      if (grant !== exp_g || bus_req !== (exp_g ? 64'hB000 : 64'hA000)) begin
        n_err++;
        $display("FAIL rr_grant txn %0d got g%b %h req g%b", k, grant,
                 bus_req, exp_g);
      end
      bus_reqack = 1;
      tick();
      bus_reqack = 0;
      n_cmp++;
      if (m0_reqack !== !exp_g || m1_reqack !== exp_g) begin
        n_err++;
        $display("FAIL rr_reqack txn %0d got %b%b", k, m1_reqack, m0_reqack);
      end
      for (int b = 0; b < 8; b++) begin
        bus_respcyc = 1; bus_resp = 64'(b);
        m0_respack = 1; m1_respack = 1;
        #1;
        n_cmp++;
        if (bus_reqcyc !== 0 || m0_respcyc !== !exp_g ||
            m1_respcyc !== exp_g) begin
          n_err++;
          $display("FAIL rr_resp txn %0d beat %0d got req %b r1 %b r0 %b",
                   k, b, bus_reqcyc, m1_respcyc, m0_respcyc);
        end
        tick();
      end
      bus_respcyc = 0;
      #1;
      n_cmp++;
      if (busy !== 0 || bus_reqcyc !== 0) begin
        n_err++;
        $display("FAIL rr_idle_gap txn %0d got busy %b reqcyc %b req 0 0",
                 k, busy, bus_reqcyc);
      end
    end
    m0_reqcyc = 0; m1_reqcyc = 0; m0_respack = 0; m1_respack = 0;
    tick();
  endtask

  task automatic test_write();
    int beats = 0;
    int cyc = 0;
    logic done = 0;
    m1_reqcyc = 1; m1_req = 64'h3000; m1_reqtag = WR;
    tick();
    n_cmp++;
    if (grant !== 1 || bus_req !== 64'h3000 || bus_reqtag !== WR) begin
      n_err++;
      $display("FAIL wr_req got g%b %h %h req g1 3000 %h",
               grant, bus_req, bus_reqtag, WR);
    end
    bus_reqack = 1;
    tick();
    n_cmp++;
    if (m1_reqack !== 1 || m0_reqack !== 0) begin
      n_err++;
      $display("FAIL wr_reqack got %b%b req 10", m1_reqack, m0_reqack);
    end
    m1_req = 64'hD0;
    for (cyc = 0; cyc < 40 && !done; cyc++) begin
      bus_reqack = (cyc % 2 == 0);
      #1;
      if (bus_reqcyc !== 1 || bus_req !== m1_req || m0_reqack !== 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_pass cyc %0d got %b %h req 1 %h",
                 cyc, bus_reqcyc, bus_req, m1_req);
      end
      if (bus_reqcyc && bus_reqack) begin
        beats++;
        tick();
        m1_req = m1_req + 1;
      end else begin
        tick();
      end
      if (!busy) done = 1;
    end
    bus_reqack = 0; m1_reqcyc = 0;
    n_cmp++;
    if (beats !== 8 || !done) begin
      n_err++;
      $display("FAIL wr_beats got %0d done %b req 8 1", beats, done);
    end
    n_cmp++;
    if (busy !== 0 || grant !== 1) begin
      n_err++;
      $display("FAIL wr_end got busy %b g%b req 0 g1", busy, grant);
    end
    m0_reqcyc = 1; m0_req = 64'h7000; m0_reqtag = RD;
    m1_reqcyc = 1; m1_req = 64'h7100; m1_reqtag = RD;
    tick();
    n_cmp++;
    if (grant !== 0 || bus_req !== 64'h7000) begin
      n_err++;
      $display("FAIL wr_last_grant_tie got g%b %h req g0 7000",
               grant, bus_req);
    end
    m0_reqcyc = 0; m1_reqcyc = 0;
    pulse_reset();
  endtask

  task automatic test_stall();
    int beats = 0;
    int stall = 0;
    logic done = 0;
    m0_reqcyc = 1; m0_req = 64'h4000; m0_reqtag = RD;
    tick();
    bus_reqack = 1;
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      bus_respcyc = 1; bus_resp = 64'h11 * (beats + 1);
      m0_respack = !(beats == 4 && stall < 3);
      #1;
      if (!m0_respack) begin
        stall++;
        n_cmp++;
        if (bus_respack !== 0 || dut.beat_cnt !== 4) begin
          n_err++;
          $display("FAIL stall_hold got ack %b cnt %0d req 0 4",
                   bus_respack, dut.beat_cnt);
        end
      end
      if (bus_respack && bus_respcyc) beats++;
      tick();
      if (!busy) done = 1;
    end
    bus_respcyc = 0; m0_respack = 0;
    n_cmp++;
    if (beats !== 8 || stall !== 3 || !done) begin
      n_err++;
      $display("FAIL stall_beats got %0d stall %0d done %b req 8 3 1",
               beats, stall, done);
    end
  endtask

  task automatic test_reset_mid();
    m0_reqcyc = 1; m0_req = 64'h5000; m0_reqtag = RD;
    tick();
    bus_reqack = 1;
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    for (int b = 0; b < 4; b++) begin
      bus_respcyc = 1; m0_respack = 1; bus_resp = 64'(b);
      tick();
    end
    bus_resp = 64'h55;
    reset = 0;
    tick();
    n_cmp++;
    if (bus_respack !== 0 || m0_respcyc !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL midreset got ack %b r0 %b busy %b req 0 0 0",
               bus_respack, m0_respcyc, busy);
    end
    reset = 1; bus_respcyc = 0; m0_respack = 0;
    m1_reqcyc = 1; m1_req = 64'h6000; m1_reqtag = RD;
    tick();
    n_cmp++;
    if (grant !== 1 || bus_reqcyc !== 1 || bus_req !== 64'h6000) begin
      n_err++;
      $display("FAIL midreset_m1_req got g%b %b %h req g1 1 6000",
               grant, bus_reqcyc, bus_req);
    end
    bus_reqack = 1;
    tick();
    bus_reqack = 0; m1_reqcyc = 0;
    for (int b = 0; b < 8; b++) begin
      bus_respcyc = 1; m1_respack = 1;
      tick();
    end
    bus_respcyc = 0; m1_respack = 0;
    m0_reqcyc = 1; m0_req = 64'h8000;
    m1_reqcyc = 1; m1_req = 64'h8100;
    tick();
    n_cmp++;
    if (grant !== 0 || bus_req !== 64'h8000) begin
      n_err++;
      $display("FAIL midreset_tie got g%b %h req g0 8000", grant, bus_req);
    end
    m0_reqcyc = 0; m1_reqcyc = 0;
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus port between two requesters: m0 (instruction fetch) and m1 (data load/store).
- Both masters use the same req/resp handshake as the bus.
- Exactly one transaction is outstanding at a time.
- Grants are round-robin. Each read returns a BEATS-beat response burst, which is routed back to the granted master only.
- Write data beats are passed through for the granted master.

Parameters:
- BUS_DATA_WIDTH, 64, width of req/resp data.
- BUS_TAG_WIDTH, 13, width of req/resp tags.
- BEATS, 8, beats per transaction (64-byte line / 8 bytes).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- m0_reqcyc / m1_reqcyc  in  1  master request valid; held until that master's reqack.
- m0_req / m1_req  in  BUS_DATA_WIDTH  address in the request phase; write data in the write-data phase.
- m0_reqtag / m1_reqtag  in  BUS_TAG_WIDTH  Sysbus tag; the command field equal to `SYSBUS_READ marks a read, anything else is a write.
- m0_reqack / m1_reqack  out  1  request (or write beat) accepted.
- m0_respcyc / m1_respcyc  out  1  response beat valid for this master.
- m0_resp / m1_resp  out  BUS_DATA_WIDTH  response data.
- m0_resptag / m1_resptag  out  BUS_TAG_WIDTH  response tag.
- m0_respack / m1_respack  in  1  master accepts the response beat.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  BUS_DATA_WIDTH  Sysbus address/data.
- bus_reqtag  out  BUS_TAG_WIDTH  Sysbus tag.
- bus_reqack  in  1  Sysbus accepted request/beat.
- bus_respcyc  in  1  Sysbus response valid.
- bus_resp  in  BUS_DATA_WIDTH  Sysbus response data.
- bus_resptag  in  BUS_TAG_WIDTH  Sysbus response tag.
- bus_respack  out  1  response beat consumed.
- grant  out  1  index of the current/last granted master.
- busy  out  1  a transaction is in progress (state != IDLE).

Behaviour:
- Reset (reset==0 at a posedge):
  - State=IDLE; all outputs 0.
  - last_grant=1, so m0 wins the first tie. beat_cnt=0.
  - Takes effect mid-transaction: the transaction is abandoned, and nothing is forwarded after the reset edge.
- States: IDLE, REQ, WDATA, RESP.
- IDLE:
  - If any mN_reqcyc is high, choose a winner: the sole requester, or if both, the one != last_grant.
  - Latch its req/tag into registers, set grant, go to REQ.
  - bus_reqcyc rises on the next cycle (1-cycle latency).
- REQ:
  - bus_reqcyc=1; bus_req/bus_reqtag come from the latched registers and stay stable until bus_reqack==1 is sampled.
  - On that edge: the granted mN_reqack pulses high for exactly 1 cycle (registered); bus_reqcyc drops; beat_cnt=0.
  - Next state: RESP if the tag is a read, else WDATA.
  - The master dropping reqcyc during REQ does not cancel the transaction.
- WDATA (write burst):
  - Combinational pass-through: bus_reqcyc = granted mN_reqcyc, bus_req = granted mN_req, mN_reqack = bus_reqack.
  - A beat counts when bus_reqcyc && bus_reqack.
  - After BEATS beats: go to IDLE; last_grant=grant.
- RESP (read burst):
  - Combinational pass-through: granted mN_respcyc = bus_respcyc, mN_resp = bus_resp, mN_resptag = bus_resptag, bus_respack = granted mN_respack.
  - A beat counts when bus_respcyc && bus_respack.
  - A master stalling (respack=0) holds the count.
  - After BEATS beats: go to IDLE; last_grant=grant.
- The non-granted master always sees respcyc=0 and reqack=0.
- A request that arrives while busy waits in its master and is arbitrated in the first IDLE cycle. There is no back-to-back grant in the cycle the burst ends; IDLE lasts at least 1 cycle.
- bus_respcyc while in IDLE/REQ/WDATA: not forwarded, bus_respack=0.
- beat_cnt is $clog2(BEATS+1) bits and does not wrap; it is cleared on entering RESP/WDATA.

Test Plan:
- Reset held low 3 cycles, with m0_reqcyc=1 throughout → all outputs 0 and busy=0. After release: bus_reqcyc=1 one cycle later with bus_req=m0_req=0x1000 and bus_reqtag=read.
- m0 read 0x2000; bus_reqack after 2 cycles; 8 response beats 0x11..0x88 → m0_reqack one 1-cycle pulse; m0 sees 8 respcyc beats with matching data; m1_respcyc stays 0; busy drops after beat 8.
- m0 and m1 request in the same cycle, both held → grants in order m0, m1, m0, m1 across 4 transactions (round-robin). The second request is not issued before the first burst completes.
- m1 write to 0x3000; bus_reqack toggles 1,0,1,… during WDATA → exactly 8 data beats forwarded; state returns to IDLE; last_grant=1.
- During RESP, m0_respack is low for 3 cycles at beat 4 → bus_respack is low those cycles; beat count freezes at 4 and the burst still completes with 8 beats.
- Reset asserted at beat 5 of a read → next cycle bus_respack=0, m0_respcyc=0, busy=0. A new m1 request afterwards is granted normally (m0 wins a subsequent tie).
